// File: rtl/idma_req_arbiter.sv
// rtl/idma_req_arbiter.sv - round-robin arbiter sharing one iDMA backend request port
module idma_req_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned ReqWidth       = 128,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumReq*ReqWidth-1:0]           req_i,
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  output logic [ReqWidth-1:0]                  be_req_o,
  output logic                                 be_valid_o,
  input  logic                                 be_ready_i,
  input  logic                                 be_done_i,
  output logic [NumReq-1:0]                    done_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 busy_o,
  output logic                                 err_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = $clog2(MaxOutstanding+1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      rr_q, rr_d;
  logic [ReqWidth-1:0]  be_req_q, be_req_d;
  logic [IdxW-1:0]      fifo_q [MaxOutstanding];
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic [NumReq-1:0]    done_q, done_d;
  logic                 err_q;

  logic                 win_found;
  logic [IdxW-1:0]      win_idx;
  logic [IdxW-1:0]      cand_idx;
  int                   cand;
  logic                 fifo_full;
  logic                 accept;
  logic                 pop;

  // Find the first valid requester scanning cyclically from the rr pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      cand = int'(rr_q) + i;
      if (cand >= int'(NumReq)) begin
        cand = cand - int'(NumReq);
      end
      cand_idx = IdxW'(cand);
      if (!win_found && req_valid_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Occupancy counts from requester acceptance, so the in-flight offer is covered.
  assign fifo_full = (count_q >= CntW'(MaxOutstanding));
  assign pop       = be_done_i && (count_q != '0);

  // FSM next state and handshake; acceptance is suppressed while reset is asserted
  // so that no request is handshaked and then dropped by the reset.
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    accept      = 1'b0;
    rr_d        = rr_q;
    be_req_d    = be_req_q;
    case (state_q)
      IDLE: begin
        if (rst_ni && win_found && !fifo_full) begin
          accept               = 1'b1;
          req_ready_o[win_idx] = 1'b1;
          be_req_d             = req_i[win_idx*ReqWidth +: ReqWidth];
          rr_d                 = (win_idx == IdxW'(NumReq-1)) ? '0 : win_idx + 1'b1;
          state_d              = OFFER;
        end
      end
      OFFER: begin
        if (be_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy and completion routing from the FIFO head.
  always_comb begin
    count_d = count_q;
    done_d  = '0;
    if (accept && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!accept && pop) begin
      count_d = count_q - 1'b1;
    end
    if (pop) begin
      done_d[fifo_q[rptr_q]] = 1'b1;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      be_req_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      be_req_q <= be_req_d;
      count_q  <= count_d;
      done_q   <= done_d;
      if (accept) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (be_done_i && (count_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Tracking FIFO storage; emptiness is defined by the pointers and count alone.
  always_ff @(posedge clk_i) begin
    if (rst_ni && accept) begin
      fifo_q[wptr_q] <= win_idx;
    end
  end

  assign be_valid_o    = (state_q == OFFER);
  assign be_req_o      = be_req_q;
  assign done_o        = done_q;
  assign outstanding_o = count_q;
  assign err_o         = err_q;
  assign busy_o        = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_idma_req_arbiter.sv
// tb/tb_idma_req_arbiter.sv - randomized self-checking bench for idma_req_arbiter
module tb_idma_req_arbiter;

  localparam int N    = 4;
  localparam int W    = 128;
  localparam int MAXO = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] req = '0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   be_req;
  logic           be_valid;
  logic           be_ready = 1'b0;
  logic           be_done = 1'b0;
  logic [N-1:0]   done;
  logic [2:0]     outstanding;
  logic           busy;
  logic           err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a queue of granted indices in issue order.
  bit         m_offer = 1'b0;
  logic [W-1:0] m_req = '0;
  int         m_rr = 0;
  int         m_q[$];
  int         m_done = -1;
  bit         m_err = 1'b0;

  logic [W-1:0] saved;
  int           obs;
  int           fair_exp[6] = '{0, 1, 2, 3, 0, 1};

  idma_req_arbiter #(
    .NumReq(N), .ReqWidth(W), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_valid_i(req_valid),
    .req_ready_o(req_ready), .be_req_o(be_req), .be_valid_o(be_valid),
    .be_ready_i(be_ready), .be_done_i(be_done), .done_o(done),
    .outstanding_o(outstanding), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int granted_index(input logic [N-1:0] r);
    int idx = -1;
    for (int k = 0; k < N; k++) if (r[k]) idx = k;
    return idx;
  endfunction

  // One clock cycle: drive inputs, compare every output with the model, advance the model.
  task automatic step(input logic rst, input logic [N-1:0] v, input logic rdy, input logic dn);
    int w;
    int c;
    logic [N-1:0] er;
    logic [N-1:0] ed;
    @(negedge clk);
    rst_n = rst; req_valid = v; be_ready = rdy; be_done = dn;
    for (int k = 0; k < N*W/32; k++) req[k*32 +: 32] = $urandom;
    #1;
    w = -1;
    if (rst && !m_offer && m_q.size() < MAXO) begin
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (v[c] && w < 0) w = c;
      end
    end
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    ed = '0;
    if (m_done >= 0) ed[m_done] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("be_valid", be_valid, m_offer);
    chk("be_req", be_req, m_req);
    chk("done", done, ed);
    chk("outstanding", outstanding, m_q.size());
    chk("busy", busy, m_offer || m_q.size() != 0);
    chk("err", err, m_err);
    if (!rst) begin
      m_offer = 1'b0; m_rr = 0; m_q.delete(); m_req = '0; m_done = -1; m_err = 1'b0;
    end else begin
      m_done = -1;
      if (dn) begin
        if (m_q.size() > 0) m_done = m_q.pop_front();
        else m_err = 1'b1;
      end
      if (m_offer && rdy) m_offer = 1'b0;
      if (w >= 0) begin
        m_q.push_back(w);
        m_offer = 1'b1;
        m_req = req[w*W +: W];
        m_rr = (w + 1) % N;
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);

    // Reset then single request with completion at cycle 5.
    step(0, 4'h0, 0, 0);
    step(1, 4'b0001, 1, 0);
    chk("t1_grant", req_ready, 4'b0001);
    saved = req[0 +: W];
    step(1, 4'h0, 1, 0);
    chk("t1_valid", be_valid, 1'b1);
    chk("t1_req", be_req, saved);
    repeat (3) step(1, 4'h0, 1, 0);
    step(1, 4'h0, 1, 1);
    step(1, 4'h0, 1, 0);
    chk("t1_done", done, 4'b0001);
    chk("t1_out", outstanding, 0);

    // Fairness: all requesting, one grant every two cycles.
    step(0, 4'h0, 0, 0);
    for (int g = 0; g < 12; g++) begin
      step(1, 4'hf, 1, logic'(g % 2));
      if (g % 2 == 0) begin
        obs = granted_index(req_ready);
        chk("fair_order", obs, fair_exp[g/2]);
      end else begin
        chk("fair_gap", req_ready, 4'b0000);
      end
    end

    // Backpressure held for 10 cycles during OFFER.
    step(1, 4'b0100, 1, 0);
    saved = be_req;
    for (int k = 0; k < 10; k++) begin
      step(1, 4'hf, 0, 0);
      chk("bp_valid", be_valid, 1'b1);
      chk("bp_ready", req_ready, 4'b0000);
    end
    step(1, 4'h0, 1, 0);
    step(1, 4'h0, 1, 0);
    chk("bp_idle", be_valid, 1'b0);

    // Fill the tracking FIFO, then free one slot.
    step(0, 4'h0, 0, 0);
    repeat (8) step(1, 4'hf, 1, 0);
    step(1, 4'hf, 1, 1);
    chk("full_out", outstanding, 4);
    chk("full_ready", req_ready, 4'b0000);
    step(1, 4'hf, 1, 0);
    chk("full_done", done, 4'b0001);
    chk("full_regrant", req_ready, 4'b0001);

    // Simultaneous push and pop at occupancy 2; completions in grant order 2,0,3.
    step(0, 4'h0, 0, 0);
    step(1, 4'b0100, 1, 0);
    step(1, 4'h0, 1, 0);
    step(1, 4'b0001, 1, 0);
    step(1, 4'h0, 1, 0);
    chk("pp_pre", outstanding, 2);
    step(1, 4'b1000, 1, 1);
    step(1, 4'h0, 1, 1);
    chk("pp_out", outstanding, 2);
    chk("pp_done0", done, 4'b0100);
    step(1, 4'h0, 1, 1);
    chk("pp_done1", done, 4'b0001);
    step(1, 4'h0, 1, 0);
    chk("pp_done2", done, 4'b1000);

    // Completion with an empty FIFO is sticky.
    step(0, 4'h0, 0, 0);
    step(1, 4'h0, 1, 1);
    step(1, 4'h0, 1, 0);
    chk("err_set", err, 1'b1);
    repeat (3) step(1, 4'h0, 1, 0);
    chk("err_sticky", err, 1'b1);

    // Reset in OFFER with three outstanding.
    step(0, 4'h0, 0, 0);
    repeat (5) step(1, 4'hf, 1, 0);
    step(1, 4'hf, 0, 0);
    chk("rst_pre_out", outstanding, 3);
    step(0, 4'hf, 0, 0);
    step(0, 4'hf, 1, 1);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_valid", be_valid, 1'b0);
    chk("rst_out", outstanding, 0);
    chk("rst_req", be_req, '0);
    chk("rst_err", err, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1, 4'h0, 1, 1);
      chk("rst_nodone", done, 4'b0000);
    end

    // Randomized traffic.
    step(0, 4'h0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      step(logic'($urandom_range(0, 99) != 0),
           4'($urandom),
           logic'($urandom_range(0, 3) != 0),
           (m_q.size() > 0) ? logic'($urandom_range(0, 2) == 0)
                            : logic'($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
